bp_be_mem_credit_ctrl: RTL and testbench

Tracks outstanding memory requests that the backend issues to the MMU/D$. It produces the credits_full/credits_empty status that the dispatch hazard logic consumes. It also sequences fence drains, by waiting until every issued memory op has returned before signalling fence completion. It sits in the checker next to the dispatch hazard logic and is fed by the MMU issue/response handshakes.

---
 rtl/bp_be_mem_credit_ctrl.sv | 143 ++++++++++++++
 tb/tb_bp_be_mem_credit_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bp_be_mem_credit_ctrl.sv
// Outstanding memory-request credit tracker with fence drain sequencing.
// Optional watchdog timeout enabled by defining BP_BE_CREDIT_WATCHDOG_EN.
module bp_be_mem_credit_ctrl #(
    parameter int credits_p         = 4,
    parameter int watchdog_cycles_p = 1024,
    parameter int credit_width_lp   = $clog2(credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       mem_issue_v_i,
    input  logic                       mem_resp_v_i,
    input  logic                       fence_v_i,
    output logic [credit_width_lp-1:0] credit_count_o,
    output logic                       credits_full_o,
    output logic                       credits_empty_o,
    output logic                       fence_busy_o,
    output logic                       fence_done_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [credit_width_lp-1:0] CreditsMax = credit_width_lp'(credits_p);

    logic [credit_width_lp-1:0] count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    state_e                     state_q;
    logic                       busy_q, done_q;

    // Errant issue/response leaves the count saturated and latches a sticky flag.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        unique case ({mem_issue_v_i, mem_resp_v_i})
            2'b10: begin
                if (count_q == CreditsMax) overflow_d = 1'b1;
                else                       count_d    = count_q + credit_width_lp'(1);
            end
            2'b01: begin
                if (count_q == '0) underflow_d = 1'b1;
                else               count_d     = count_q - credit_width_lp'(1);
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // DRAIN exit looks at the registered count, so the last response must land first.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (fence_v_i) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((count_q == '0) && !mem_issue_v_i) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (fence_v_i) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BP_BE_CREDIT_WATCHDOG_EN
    localparam int wd_width_lp = $clog2(watchdog_cycles_p + 1);
    localparam logic [wd_width_lp-1:0] WdMax = wd_width_lp'(watchdog_cycles_p);

    logic [wd_width_lp-1:0] wd_q, wd_d;
    logic                   timeout_q;

    always_comb begin
        wd_d = wd_q;
        if (mem_resp_v_i || (count_q == '0)) wd_d = '0;
        else if (wd_q != WdMax)              wd_d = wd_q + wd_width_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == WdMax) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign credit_count_o  = count_q;
    assign credits_full_o  = (count_q == CreditsMax);
    assign credits_empty_o = (count_q == '0);
    assign fence_busy_o    = busy_q;
    assign fence_done_o    = done_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_bp_be_mem_credit_ctrl.sv
// Directed table-driven bench for bp_be_mem_credit_ctrl (credits_p=4).
module tb_bp_be_mem_credit_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue = 1'b0, resp = 1'b0, fence = 1'b0;
    logic [2:0] count;
    logic       full, empty, busy, done, ovf, unf, tmo;

    int errors = 0;
    int checks = 0;

    bp_be_mem_credit_ctrl #(
        .credits_p(4),
        .watchdog_cycles_p(8)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .mem_issue_v_i(issue),
        .mem_resp_v_i(resp),
        .fence_v_i(fence),
        .credit_count_o(count),
        .credits_full_o(full),
        .credits_empty_o(empty),
        .fence_busy_o(busy),
        .fence_done_o(done),
        .overflow_o(ovf),
        .underflow_o(unf),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic i, r, f;
        int   cnt;
        logic full, empty, busy, done, ovf, unf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic i, input logic r, input logic f);
        @(negedge clk);
        issue = i; resp = r; fence = f;
        @(posedge clk);
        #1;
        issue = 1'b0; resp = 1'b0; fence = 1'b0;
    endtask

    task automatic add(input logic i, r, f, input int cnt,
                       input logic fu, em, bu, dn, ov, un);
        vq.push_back('{i, r, f, cnt, fu, em, bu, dn, ov, un});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".empty"}, int'(empty), 1);
        chk({tag, ".full"},  int'(full),  0);
        chk({tag, ".busy"},  int'(busy),  0);
        chk({tag, ".done"},  int'(done),  0);
        chk({tag, ".ovf"},   int'(ovf),   0);
        chk({tag, ".unf"},   int'(unf),   0);
        chk({tag, ".tmo"},   int'(tmo),   0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        //   i  r  f  cnt full empty busy done ovf unf
        // fill to full, simultaneous issue+resp at full, drain
        add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 4, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fence with nothing outstanding: done two cycles after fence
        add(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fence arriving in DONE re-enters DRAIN
        add(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fence with 3 outstanding; issue at count==0 holds DRAIN
        add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 2, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // overflow then underflow, both sticky
        add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 3, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 2, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);

        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[k]) begin
            string n;
            step(vq[k].i, vq[k].r, vq[k].f);
            n = $sformatf("v%0d", k);
            chk({n, ".count"}, int'(count), vq[k].cnt);
            chk({n, ".full"},  int'(full),  int'(vq[k].full));
            chk({n, ".empty"}, int'(empty), int'(vq[k].empty));
            chk({n, ".busy"},  int'(busy),  int'(vq[k].busy));
            chk({n, ".done"},  int'(done),  int'(vq[k].done));
            chk({n, ".ovf"},   int'(ovf),   int'(vq[k].ovf));
            chk({n, ".unf"},   int'(unf),   int'(vq[k].unf));
            chk({n, ".tmo"},   int'(tmo),   0);
        end

        // asynchronous reset mid-cycle while draining with count=2
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        chk("pre_rst.count", int'(count), 2);
        chk("pre_rst.busy",  int'(busy),  1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0);
            chk($sformatf("post_rst%0d.done", c), int'(done), 0);
            chk($sformatf("post_rst%0d.busy", c), int'(busy), 0);
        end

`ifdef BP_BE_CREDIT_WATCHDOG_EN
        // one issue, no responses: timeout exactly 8 cycles later
        do_reset();
        step(1, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            step(0, 0, 0);
            chk($sformatf("wd_c%0d.tmo", c), int'(tmo), (c == 8) ? 1 : 0);
        end
        step(0, 0, 0);
        chk("wd_sticky.tmo", int'(tmo), 1);
        // response at cycle 7 clears the watchdog
        do_reset();
        step(1, 0, 0);
        for (int c = 1; c <= 6; c++) step(0, 0, 0);
        step(0, 1, 0);
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 0);
            chk($sformatf("wd_resp%0d.tmo", c), int'(tmo), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
